// File: rtl/npn4_canon_seq.sv
// Sequential NPN canonicaliser for 4-input Boolean functions.
// Walks every (permutation, input mask, output negation) candidate, one per cycle,
// and keeps the smallest transformed truth table together with its transform.
module npn4_canon_seq #(
    parameter bit ENABLE_ONEG = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_tt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] canon_tt,
    output logic [4:0]  perm_idx,
    output logic [3:0]  neg_mask,
    output logic        out_neg
);

    typedef enum logic [1:0] {StIdle, StScan, StDone} state_e;

    state_e      state_q, state_d;
    logic [15:0] src_tt_q;
    logic [4:0]  perm_q;
    logic [3:0]  mask_q;
    logic        oneg_q;
    logic [15:0] best_tt_q;
    logic [4:0]  best_perm_q;
    logic [3:0]  best_mask_q;
    logic        best_oneg_q;
    logic [15:0] canon_q;
    logic [4:0]  canon_perm_q;
    logic [3:0]  canon_mask_q;
    logic        canon_oneg_q;

    logic [15:0] cand_tt;
    logic        cand_better;
    logic        last_cand;
    logic [15:0] sel_tt;
    logic [4:0]  sel_perm;
    logic [3:0]  sel_mask;
    logic        sel_oneg;

    // Permutation tuple for a perm index, packed {p0,p1,p2,p3} with p0 in the top bits.
    function automatic logic [7:0] perm_tuple(input logic [4:0] idx);
        logic [7:0] t;
        case (idx)
            5'd0:    t = {2'd0, 2'd1, 2'd2, 2'd3};
            5'd1:    t = {2'd0, 2'd1, 2'd3, 2'd2};
            5'd2:    t = {2'd0, 2'd2, 2'd1, 2'd3};
            5'd3:    t = {2'd0, 2'd2, 2'd3, 2'd1};
            5'd4:    t = {2'd0, 2'd3, 2'd1, 2'd2};
            5'd5:    t = {2'd0, 2'd3, 2'd2, 2'd1};
            5'd6:    t = {2'd1, 2'd0, 2'd2, 2'd3};
            5'd7:    t = {2'd1, 2'd0, 2'd3, 2'd2};
            5'd8:    t = {2'd1, 2'd2, 2'd0, 2'd3};
            5'd9:    t = {2'd1, 2'd2, 2'd3, 2'd0};
            5'd10:   t = {2'd1, 2'd3, 2'd0, 2'd2};
            5'd11:   t = {2'd1, 2'd3, 2'd2, 2'd0};
            5'd12:   t = {2'd2, 2'd0, 2'd1, 2'd3};
            5'd13:   t = {2'd2, 2'd0, 2'd3, 2'd1};
            5'd14:   t = {2'd2, 2'd1, 2'd0, 2'd3};
            5'd15:   t = {2'd2, 2'd1, 2'd3, 2'd0};
            5'd16:   t = {2'd2, 2'd3, 2'd0, 2'd1};
            5'd17:   t = {2'd2, 2'd3, 2'd1, 2'd0};
            5'd18:   t = {2'd3, 2'd0, 2'd1, 2'd2};
            5'd19:   t = {2'd3, 2'd0, 2'd2, 2'd1};
            5'd20:   t = {2'd3, 2'd1, 2'd0, 2'd2};
            5'd21:   t = {2'd3, 2'd1, 2'd2, 2'd0};
            5'd22:   t = {2'd3, 2'd2, 2'd0, 2'd1};
            5'd23:   t = {2'd3, 2'd2, 2'd1, 2'd0};
            default: t = {2'd0, 2'd1, 2'd2, 2'd3};
        endcase
        return t;
    endfunction

    // T'[k] = o ^ T[k'], k'[i] = k[p_i] ^ m[i].
    function automatic logic [15:0] xform(input logic [15:0] tt, input logic [7:0] tup,
                                          input logic [3:0] m, input logic o);
        logic [15:0] r;
        logic [3:0]  k;
        logic [3:0]  kp;
        r  = '0;
        kp = '0;
        for (int j = 0; j < 16; j++) begin
            k = 4'(j);
            for (int i = 0; i < 4; i++) begin
                kp[i] = k[tup[7-2*i -: 2]] ^ m[i];
            end
            r[j] = o ^ tt[kp];
        end
        return r;
    endfunction

    // Evaluate the current candidate and pick the running minimum (strictly-less wins).
    always_comb begin
        cand_tt     = xform(src_tt_q, perm_tuple(perm_q), mask_q, oneg_q);
        cand_better = cand_tt < best_tt_q;
        last_cand   = (perm_q == 5'd23) && (mask_q == 4'd15) && (oneg_q || !ENABLE_ONEG);
        sel_tt      = cand_better ? cand_tt : best_tt_q;
        sel_perm    = cand_better ? perm_q  : best_perm_q;
        sel_mask    = cand_better ? mask_q  : best_mask_q;
        sel_oneg    = cand_better ? oneg_q  : best_oneg_q;
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                if (in_valid) state_d = StScan;
            end
            StScan: begin
                if (last_cand) state_d = StDone;
            end
            StDone: begin
                out_valid = 1'b1;
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // Scan counters, running best and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_tt_q     <= '0;
            perm_q       <= '0;
            mask_q       <= '0;
            oneg_q       <= 1'b0;
            best_tt_q    <= '0;
            best_perm_q  <= '0;
            best_mask_q  <= '0;
            best_oneg_q  <= 1'b0;
            canon_q      <= '0;
            canon_perm_q <= '0;
            canon_mask_q <= '0;
            canon_oneg_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        src_tt_q    <= in_tt;
                        best_tt_q   <= in_tt;
                        best_perm_q <= '0;
                        best_mask_q <= '0;
                        best_oneg_q <= 1'b0;
                        perm_q      <= '0;
                        mask_q      <= '0;
                        oneg_q      <= 1'b0;
                    end
                end
                StScan: begin
                    best_tt_q   <= sel_tt;
                    best_perm_q <= sel_perm;
                    best_mask_q <= sel_mask;
                    best_oneg_q <= sel_oneg;
                    if (last_cand) begin
                        canon_q      <= sel_tt;
                        canon_perm_q <= sel_perm;
                        canon_mask_q <= sel_mask;
                        canon_oneg_q <= sel_oneg;
                    end else if (ENABLE_ONEG && !oneg_q) begin
                        oneg_q <= 1'b1;
                    end else begin
                        oneg_q <= 1'b0;
                        mask_q <= mask_q + 4'd1;
                        if (mask_q == 4'd15) perm_q <= perm_q + 5'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign canon_tt = canon_q;
    assign perm_idx = canon_perm_q;
    assign neg_mask = canon_mask_q;
    assign out_neg  = canon_oneg_q;

endmodule

// File: doc/npn4_canon_seq.md
Name: npn4_canon_seq

Overview:
- Sequential NPN canonicaliser for 4-input Boolean functions.
- Accepts a 16-bit truth table and scans every input permutation, input-negation mask and output negation, one candidate per cycle.
- Returns the minimum-valued equivalent truth table (the NPN class representative) plus the transform that produces it.
- Sits in front of the exact-synthesis AIG library: the representative selects the stored AIG, and the transform tells downstream logic how to rewire x0..x3 and y0.

Parameters:
- ENABLE_ONEG, 1, when 1 output negation is scanned (full NPN); when 0 only NP transforms are scanned.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  truth table offered.
- in_ready  output  1  block can accept a truth table.
- in_tt  input  16  truth table; bit k = f(x3,x2,x1,x0) with k = {x3,x2,x1,x0}.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- canon_tt  output  16  canonical (minimum) truth table.
- perm_idx  output  5  permutation index 0..23.
- neg_mask  output  4  input negation mask, bit i applies to input i.
- out_neg  output  1  output negation.

Behaviour:
- Transform (p, m, o) definition:
  - T'[k] = o XOR T[k'], where bit i of k' = (bit p[i] of k) XOR m[i].
  - p is the permutation tuple (p0,p1,p2,p3).
  - perm_idx enumerates tuples over {0,1,2,3} in lexicographic order: 0 = (0,1,2,3), 1 = (0,1,3,2), ..., 18 = (3,0,1,2), 23 = (3,2,1,0).
- Scan order: perm outer (0..23), mask middle (0..15), o inner (0..1).
  - With ENABLE_ONEG=0, o is fixed at 0.
  - 768 candidates when ENABLE_ONEG=1, 384 when 0.
- Selection: candidate replaces best only if strictly less as an unsigned 16-bit value. Ties keep the earliest candidate in scan order.
- FSM states:
  - IDLE: in_ready=1, out_valid=0. On in_valid&&in_ready, latch in_tt, initialise best = in_tt with transform (0,0,0), clear counters, go to SCAN.
  - SCAN: in_ready=0. One candidate evaluated and compared per cycle. After the final candidate's compare edge, go to DONE.
  - DONE: out_valid=1; canon_tt/perm_idx/neg_mask/out_neg stable. On out_valid&&out_ready, go to IDLE. The next input is accepted no earlier than the following cycle.
- Latency: out_valid rises exactly N cycles after the accept edge, where N = 768 (ENABLE_ONEG=1) or 384 (ENABLE_ONEG=0).
- Backpressure: DONE holds indefinitely while out_ready=0; outputs must not change.
- in_valid during SCAN/DONE is ignored; the input is not latched and in_ready stays 0.
- Outputs are registered. canon_tt and the transform fields are valid only while out_valid=1; they keep their last values otherwise.
- Reset (asserted at any time, including mid-scan or in DONE):
  - state -> IDLE, all counters and best registers cleared.
  - in_ready=1 (after reset), out_valid=0, canon_tt=16'h0000, perm_idx=0, neg_mask=0, out_neg=0.
  - A scan interrupted by reset produces no result.
- Permutation tuples come from a 24-entry constant table indexed by perm_idx. No arithmetic wrap beyond the counter terminal values: perm 23 / mask 15 / o 1 is the last candidate.

Test Plan:
- in_tt=16'h0000 -> after 768 cycles: canon_tt=16'h0000, perm_idx=0, neg_mask=4'h0, out_neg=0.
- in_tt=16'hFFFF -> canon_tt=16'h0000, perm_idx=0, neg_mask=4'h0, out_neg=1. With ENABLE_ONEG=0 -> canon_tt=16'hFFFF, perm 0, mask 0, after 384 cycles.
- in_tt=16'h8000 (AND4) -> canon_tt=16'h0001, perm_idx=0, neg_mask=4'hF, out_neg=0.
- in_tt=16'hAAAA (f=x0) -> canon_tt=16'h00FF, perm_idx=18, neg_mask=4'h0, out_neg=1. Hold out_ready=0 for 50 cycles: outputs stable, in_ready=0, extra in_valid pulses ignored.
- Drop rst_n for 1 cycle at cycle 300 of a scan of 16'h6996 -> out_valid stays 0, in_ready=1 after reset; resubmitting completes normally.
- Random in_tt sweep (all 65536 values): apply the reported (perm_idx, neg_mask, out_neg) to in_tt in the bench model; result must equal canon_tt and match the reference minimum. Functions in the same NPN class must yield identical canon_tt.
